// File: rtl/led_pattern_sequencer.sv
// Push-button LED pattern sequencer (IDLE/SHL/SHR/BLINK); define LED_SEQ_DEBOUNCE_EN to add the debounce stage.
// Latency: btn edge to press pulse 3 cycles (DB_CYCLES+3 with debounce); led/mode/paused update one cycle later.
// Backpressure: none; buttons are sampled every cycle and all outputs are always valid.
module led_pattern_sequencer #(
    parameter int CLK_DIV   = 12_500_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       paused
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHL   = 2'd1,
        SHR   = 2'd2,
        BLINK = 2'd3
    } state_t;

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    localparam int            PW    = $clog2(CLK_DIV);
    localparam logic [PW-1:0] P_MAX = PW'(CLK_DIV - 1);

    logic [1:0] sync_a;
    logic [1:0] sync_b;
    logic [1:0] level;
    logic [1:0] level_q;
    logic [1:0] press;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    // Accepted level flips only after the synchronised input disagrees for DB_CYCLES cycles in a row.
    if (DB_EN) begin : g_debounce
        localparam int            DW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
        localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);

        for (genvar i = 0; i < 2; i++) begin : g_bit
            logic [DW-1:0] cnt;
            logic          lvl;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt <= '0;
                    lvl <= 1'b0;
                end else if (sync_b[i] == lvl) begin
                    cnt <= '0;
                end else if (cnt == DB_MAX) begin
                    cnt <= '0;
                    lvl <= sync_b[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign level[i] = lvl;
        end
    end else begin : g_no_debounce
        assign level = sync_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 2'b00;
            press   <= 2'b00;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

    state_t        state;
    logic [PW-1:0] presc;
    logic          mode_press;
    logic          pause_press;
    logic          running;
    logic          step;

    assign mode_press  = press[0];
    assign pause_press = press[1];
    assign running     = (state != IDLE) && !paused;
    assign step        = running && (presc == P_MAX);
    assign mode        = state;

    function automatic state_t next_state(input state_t s);
        case (s)
            IDLE:    return SHL;
            SHL:     return SHR;
            SHR:     return BLINK;
            default: return IDLE;
        endcase
    endfunction

    function automatic logic [3:0] entry_led(input state_t s);
        case (s)
            SHL:     return 4'b0001;
            SHR:     return 4'b1000;
            BLINK:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // A press always takes priority over a step landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            led    <= 4'b0000;
            paused <= 1'b0;
            presc  <= '0;
        end else if (mode_press && pause_press) begin
            state  <= IDLE;
            led    <= 4'b0000;
            paused <= 1'b0;
            presc  <= '0;
        end else if (mode_press) begin
            state  <= next_state(state);
            led    <= entry_led(next_state(state));
            paused <= 1'b0;
            presc  <= '0;
        end else begin
            if (running) begin
                presc <= (presc == P_MAX) ? '0 : presc + 1'b1;
            end
            if (pause_press && (state != IDLE)) begin
                paused <= !paused;
            end else if (step) begin
                case (state)
                    SHL:     led <= {led[2:0], led[3]};
                    SHR:     led <= {led[0], led[3:1]};
                    BLINK:   led <= ~led;
                    default: led <= led;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised bench for led_pattern_sequencer: outputs are compared every cycle against a
// model built from button-acceptance windows, press latency and running-cycle counts.
module tb_led_pattern_sequencer;

    localparam int CLK_DIV   = 4;
    localparam int DB_CYCLES = 3;
`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int WIN = DB_CYCLES;
    localparam int LAT = 4;
`else
    localparam int WIN = 1;
    localparam int LAT = 3;
`endif
    localparam int MAXC = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn;
    logic [3:0] led;
    logic [1:0] mode;
    logic       paused;

    led_pattern_sequencer #(
        .CLK_DIV   (CLK_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .led    (led),
        .mode   (mode),
        .paused (paused)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         n      = 0;
    logic [1:0] hist[$];
    logic [1:0] acc;
    bit   [1:0] sched [MAXC];
    int         m_mode;
    int         m_led;
    int         m_run;
    logic       m_paused;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic int entry_led(input int md);
        case (md)
            1:       return 1;
            2:       return 8;
            3:       return 15;
            default: return 0;
        endcase
    endfunction

    function automatic int advance(input int md, input int l);
        if (md == 1) return (l * 2 > 15) ? l * 2 - 15 : l * 2;
        if (md == 2) return (l == 1) ? 8 : l / 2;
        if (md == 3) return 15 - l;
        return l;
    endfunction

    // A button level is accepted once the last WIN raw samples all disagree with it;
    // an accepted rise acts on the FSM LAT edges after its final sample.
    task automatic model_edge(input logic [1:0] b, input logic r);
        logic pm;
        logic pp;
        logic run_en;
        logic is_step;
        logic differs;
        if (r) begin
            hist.delete();
            for (int i = 0; i < WIN; i++) hist.push_back(2'b00);
            acc = 2'b00;
            for (int k = n; k <= n + LAT && k < MAXC; k++) sched[k] = 2'b00;
            m_mode   = 0;
            m_led    = 0;
            m_paused = 1'b0;
            m_run    = 0;
            return;
        end
        hist.push_back(b);
        void'(hist.pop_front());
        for (int i = 0; i < 2; i++) begin
            differs = 1'b1;
            foreach (hist[j]) if (hist[j][i] == acc[i]) differs = 1'b0;
            if (differs) begin
                acc[i] = ~acc[i];
                if (acc[i] && (n + LAT < MAXC)) sched[n + LAT][i] = 1'b1;
            end
        end
        pm = sched[n][0];
        pp = sched[n][1];
        if (pm && pp) begin
            m_mode   = 0;
            m_led    = 0;
            m_paused = 1'b0;
            m_run    = 0;
        end else if (pm) begin
            m_mode   = (m_mode + 1) % 4;
            m_led    = entry_led(m_mode);
            m_paused = 1'b0;
            m_run    = 0;
        end else begin
            run_en  = (m_mode != 0) && !m_paused;
            is_step = run_en && ((m_run % CLK_DIV) == CLK_DIV - 1);
            if (run_en) m_run++;
            if (pp && (m_mode != 0)) m_paused = !m_paused;
            else if (is_step) m_led = advance(m_mode, m_led);
        end
    endtask

    task automatic cycle(input logic [1:0] b, input logic r);
        btn = b;
        rst = r;
        @(posedge clk);
        n++;
        model_edge(b, r);
        #1;
        check("led", led, m_led);
        check("mode", mode, m_mode);
        check("paused", paused, m_paused);
    endtask

    task automatic hold(input logic [1:0] b, input int len);
        for (int k = 0; k < len; k++) cycle(b, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < WIN; i++) hist.push_back(2'b00);
        acc      = 2'b00;
        m_mode   = 0;
        m_led    = 0;
        m_paused = 1'b0;
        m_run    = 0;

        // reset, then a quiet idle stretch
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);
        hold(2'b00, 50);

        // long MODE hold into SHL, then SHR, BLINK and back to IDLE
        hold(2'b01, 20);
        hold(2'b00, 30);
        for (int p = 0; p < 3; p++) begin
            hold(2'b01, 10);
            hold(2'b00, 24);
        end

        // pause and resume inside SHL
        hold(2'b01, 10);
        for (int k = 0; k < 40 && m_led != 2; k++) hold(2'b00, 1);
        hold(2'b10, 8);
        hold(2'b00, 40);
        hold(2'b10, 8);
        hold(2'b00, 20);

        // PAUSE in IDLE is ignored
        cycle(2'b00, 1'b1);
        hold(2'b10, 10);
        hold(2'b00, 15);

        // bouncing MODE input followed by a clean hold
        for (int k = 0; k < 8; k++) begin
            hold(2'b01, 2);
            hold(2'b00, 2);
        end
        hold(2'b01, 20);
        hold(2'b00, 12);

        // into BLINK, then MODE and PAUSE together
        for (int p = 0; p < 2; p++) begin
            hold(2'b01, 10);
            hold(2'b00, 12);
        end
        hold(2'b11, 10);
        hold(2'b00, 20);

        // reset in the middle of SHL
        hold(2'b01, 10);
        hold(2'b00, 9);
        cycle(2'b00, 1'b1);
        hold(2'b00, 10);

        // random button activity with occasional resets
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 99) == 0) cycle(2'b00, 1'b1);
            hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 14)));
        end
        hold(2'b00, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
